linescanner_line_collector: RTL
===============================

LINESCANNER_LINE_COLLECTOR -- requirements
Module: linescanner_line_collector

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 256, pixels per line (legal range 2..1024).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, buffer address width (2^ADDR_WIDTH >= LINE_LENGTH).
REQ-003 SHALL have port main_clock_source  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  capture enable; low aborts any partial line.
REQ-006 SHALL have port pixel_data  in  8  incoming pixel value.
REQ-007 SHALL have port pixel_captured  in  1  pixel_data is valid this cycle.
REQ-008 SHALL have port read_enable  in  1  consumer request for the next stored pixel.
REQ-009 SHALL have port read_data  out  8  registered pixel output.
REQ-010 SHALL have port read_valid  out  1  read_data valid this cycle.
REQ-011 SHALL have port line_end  out  1  high with read_valid on the last pixel of a line.
REQ-012 SHALL have port line_ready  out  1  a complete line is available for reading.
REQ-013 SHALL have port overflow  out  1  sticky; a line was dropped because both buffers were full.
REQ-014 SHALL have port lines_captured  out  16  count of committed lines, wrapping 65535->0.

Function
REQ-015 SHALL contain two line buffers B0/B1 (LINE_LENGTH x 8), write pointers wbuf/wr_addr, read pointers rbuf/rd_addr, and per-buffer full flags.
REQ-016 Write FSM SHALL have states IDLE, FILL, DISCARD; it SHALL be in IDLE when enable=0, with wr_addr=0 and any partial line discarded; full buffers SHALL be retained.
REQ-017 IDLE->FILL SHALL occur on the first edge with enable=1; the pixel accepted on that edge is pixel 0 of a line.
REQ-018 In FILL, on an edge with pixel_captured=1, the pixel SHALL be written to B[wbuf][wr_addr] and wr_addr incremented; pixel_captured=0 SHALL hold all state.
REQ-019 On the write of pixel LINE_LENGTH-1: full[wbuf] set, wbuf toggled, wr_addr cleared, lines_captured incremented, same edge.
REQ-020 A pixel arriving in FILL with wr_addr=0 and full[wbuf]=1 SHALL be dropped; FSM SHALL enter DISCARD, overflow SHALL be set.
REQ-021 DISCARD SHALL count LINE_LENGTH pixels including the first dropped one, then return to FILL with wr_addr=0, preserving line alignment even if a buffer frees mid-discard.
REQ-022 line_ready SHALL equal full[rbuf], driven from registers only (no combinational input path).
REQ-023 On an edge with read_enable=1 and line_ready=1: read_data<=B[rbuf][rd_addr], read_valid<=1, rd_addr incremented; read_valid is therefore one-cycle latency.
REQ-024 On the read of rd_addr=LINE_LENGTH-1: line_end<=1, full[rbuf] cleared, rbuf toggled, rd_addr cleared.
REQ-025 read_enable while line_ready=0 SHALL be ignored: read_valid<=0, line_end<=0, read_data holds.
REQ-026 A line commit and a line release on the same edge SHALL both take effect (different buffers).
REQ-027 Minimum latency: line_ready high the cycle after the edge writing the last pixel.
REQ-028 overflow SHALL clear only on reset or while enable=0.
REQ-029 Read side SHALL operate independently of enable.

Reset
REQ-030 n_reset low SHALL immediately force: read_data=0, read_valid=0, line_end=0, line_ready=0, overflow=0, lines_captured=0, both full flags 0, all pointers 0, FSM=IDLE; buffer contents undefined.
REQ-031 Reset asserted mid-line or mid-read SHALL discard all stored lines; the first line after release starts at pixel 0.

Verification (LINE_LENGTH=4)
REQ-032 Reset: assert n_reset mid-stream -> all outputs 0 asynchronously, before next clock edge.
REQ-033 Basic: enable=1, pixels 0,1,2,3 with pixel_captured -> line_ready=1, lines_captured=1; 4 reads -> read_data 0,1,2,3, line_end on 3, then line_ready=0.
REQ-034 Overflow: pixels 0..11, no reads -> lines_captured=2, overflow=1; 8 reads -> 0..7; 8..11 never appear.
REQ-035 Abort: pixels 0,1 then enable=0 one cycle, enable=1, pixels 10..13 -> line read = 10,11,12,13; lines_captured=1.
REQ-036 Streaming: continuous 0..255 pixel source with read_enable held high -> read stream equals input order, no overflow, line_end every 4th read_valid.
REQ-037 Idle read: read_enable=1 with line_ready=0 for 5 cycles -> read_valid stays 0; a following line reads from pixel 0.

Source files
------------

// File: rtl/linescanner_line_collector.sv
// ---------------------------------------------------------------------------
// linescanner_line_collector
//
// Collects incoming pixels into one of two line buffers (ping-pong) and hands
// complete lines to a consumer one pixel per read request.
//
// Parameters
//   LINE_LENGTH  pixels per line (2..1024)
//   ADDR_WIDTH   buffer address width, 2**ADDR_WIDTH >= LINE_LENGTH
//
// Ports
//   main_clock_source  in   single clock, rising edge
//   n_reset            in   asynchronous active-low reset
//   enable             in   capture enable; low aborts a partial line
//   pixel_data[7:0]    in   incoming pixel
//   pixel_captured     in   pixel_data valid this cycle
//   read_enable        in   consumer request for the next stored pixel
//   read_data[7:0]     out  registered pixel output
//   read_valid         out  read_data valid this cycle
//   line_end           out  with read_valid on the last pixel of a line
//   line_ready         out  a complete line is available for reading
//   overflow           out  sticky; a line was dropped (both buffers full)
//   lines_captured     out  count of committed lines, wraps at 16 bits
// ---------------------------------------------------------------------------
module linescanner_line_collector #(
  parameter int unsigned LINE_LENGTH = 256,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic        main_clock_source,
  input  logic        n_reset,
  input  logic        enable,
  input  logic [7:0]  pixel_data,
  input  logic        pixel_captured,
  input  logic        read_enable,
  output logic [7:0]  read_data,
  output logic        read_valid,
  output logic        line_end,
  output logic        line_ready,
  output logic        overflow,
  output logic [15:0] lines_captured
);

  localparam int unsigned           Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LINE_LENGTH - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDiscard} wr_state_e;

  // Line storage; contents are don't-care after reset, so no reset here.
  logic [7:0] buf_mem [2][Depth];

  // Write side state
  wr_state_e             state_q, state_d;
  logic                  wbuf_q, wbuf_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           lines_q, lines_d;
  logic                  mem_we;
  logic                  commit;

  // Read side state
  logic                  rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]            full_q, full_d;
  logic [7:0]            read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  line_end_q, line_end_d;
  logic                  rd_fire;
  logic                  release_line;

  // -------------------------------------------------------------------------
  // Write FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wbuf_d     = wbuf_q;
    wr_addr_d  = wr_addr_q;
    overflow_d = overflow_q;
    lines_d    = lines_q;
    mem_we     = 1'b0;
    commit     = 1'b0;

    if (!enable) begin
      // Drop any partial line; committed lines stay in their buffers.
      state_d    = StIdle;
      wr_addr_d  = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        // The first enabled edge already accepts pixel 0, so IDLE and FILL
        // share the same capture behaviour.
        StIdle, StFill: begin
          state_d = StFill;
          if (pixel_captured) begin
            if ((wr_addr_q == '0) && full_q[wbuf_q]) begin
              // Nowhere to put this line: skip it whole to keep alignment.
              // wr_addr doubles as the discard counter; this pixel is #0.
              state_d    = StDiscard;
              overflow_d = 1'b1;
              wr_addr_d  = ADDR_WIDTH'(1);
            end else begin
              mem_we = 1'b1;
              if (wr_addr_q == LastAddr) begin
                commit    = 1'b1;
                wbuf_d    = ~wbuf_q;
                wr_addr_d = '0;
                lines_d   = lines_q + 16'd1;
              end else begin
                wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
              end
            end
          end
        end
        StDiscard: begin
          if (pixel_captured) begin
            if (wr_addr_q == LastAddr) begin
              state_d   = StFill;
              wr_addr_d = '0;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d   = StIdle;
          wr_addr_d = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read side
  // -------------------------------------------------------------------------
  assign rd_fire      = read_enable & full_q[rbuf_q];
  assign release_line = rd_fire & (rd_addr_q == LastAddr);

  always_comb begin
    rbuf_d       = rbuf_q;
    rd_addr_d    = rd_addr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    line_end_d   = 1'b0;

    if (rd_fire) begin
      read_data_d  = buf_mem[rbuf_q][rd_addr_q];
      read_valid_d = 1'b1;
      if (release_line) begin
        line_end_d = 1'b1;
        rbuf_d     = ~rbuf_q;
        rd_addr_d  = '0;
      end else begin
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Commit and release always target different buffers (a commit needs the
  // write buffer empty, a release needs the read buffer full), so both apply.
  always_comb begin
    full_d = full_q;
    if (commit) begin
      full_d[wbuf_q] = 1'b1;
    end
    if (release_line) begin
      full_d[rbuf_q] = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge main_clock_source or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      wbuf_q       <= 1'b0;
      wr_addr_q    <= '0;
      overflow_q   <= 1'b0;
      lines_q      <= '0;
      rbuf_q       <= 1'b0;
      rd_addr_q    <= '0;
      full_q       <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      line_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbuf_q       <= wbuf_d;
      wr_addr_q    <= wr_addr_d;
      overflow_q   <= overflow_d;
      lines_q      <= lines_d;
      rbuf_q       <= rbuf_d;
      rd_addr_q    <= rd_addr_d;
      full_q       <= full_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      line_end_q   <= line_end_d;
    end
  end

  always_ff @(posedge main_clock_source) begin
    if (mem_we) begin
      buf_mem[wbuf_q][wr_addr_q] <= pixel_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign read_data      = read_data_q;
  assign read_valid     = read_valid_q;
  assign line_end       = line_end_q;
  assign line_ready     = full_q[rbuf_q];
  assign overflow       = overflow_q;
  assign lines_captured = lines_q;

endmodule
